axi_burst_master: RTL and testbench

- AXI4 master that drives the `memory` slave's AW/W/B/AR/R channels.
- Converts a simple command interface (write/read, address, beat count) into single INCR bursts.
- Streams write data in and read data out; reports a per-command completion status.
- One transaction outstanding at a time; upstream is the test/traffic logic or a cache-side client.

---
 rtl/axi_burst_master.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// AXI4 burst master: turns simple write/read commands into single INCR bursts.
// One transaction outstanding; W and R beats are streamed straight through.
module axi_burst_master #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 32,
    parameter int ID_WIDTH      = 1,
    parameter int MASTER_ID     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic                      wd_valid,
    output logic                      wd_ready,
    input  logic [DATA_WIDTH-1:0]     wd_data,
    input  logic [DATA_WIDTH/8-1:0]   wd_strb,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_last,
    output logic                      rsp_valid,
    output logic                      rsp_write,
    output logic                      rsp_err,
    output logic [ID_WIDTH-1:0]       aw_id,
    output logic [ADDRESS_WIDTH-1:0]  aw_addr,
    output logic [7:0]                aw_len,
    output logic [2:0]                aw_size,
    output logic [1:0]                aw_burst,
    output logic [3:0]                aw_cache,
    output logic [2:0]                aw_prot,
    output logic [3:0]                aw_qos,
    output logic [3:0]                aw_region,
    output logic                      aw_valid,
    input  logic                      aw_ready,
    output logic [DATA_WIDTH-1:0]     w_data,
    output logic [DATA_WIDTH/8-1:0]   w_strb,
    output logic                      w_last,
    output logic                      w_valid,
    input  logic                      w_ready,
    input  logic [1:0]                b_resp,
    input  logic [ID_WIDTH-1:0]       b_id,
    input  logic                      b_valid,
    output logic                      b_ready,
    output logic [ID_WIDTH-1:0]       ar_id,
    output logic [ADDRESS_WIDTH-1:0]  ar_addr,
    output logic [7:0]                ar_len,
    output logic [2:0]                ar_size,
    output logic [1:0]                ar_burst,
    output logic [3:0]                ar_cache,
    output logic [2:0]                ar_prot,
    output logic [3:0]                ar_qos,
    output logic [3:0]                ar_region,
    output logic                      ar_valid,
    input  logic                      ar_ready,
    input  logic [ID_WIDTH-1:0]       r_id,
    input  logic [DATA_WIDTH-1:0]     r_data,
    input  logic [1:0]                r_resp,
    input  logic                      r_last,
    input  logic                      r_valid,
    output logic                      r_ready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_ERR
    } state_t;

    state_t                     state, state_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [7:0]                 len_q;
    logic                       write_q;
    logic [7:0]                 beat;
    logic                       rd_err_q;
    logic                       done;
    logic                       done_err;

    logic [ADDRESS_WIDTH-1:0]   aligned;
    logic [16:0]                span;
    logic [16:0]                end_off;
    logic                       cross_4k;
    logic                       accept;
    logic                       last_beat;
    logic                       w_hs;
    logic                       r_hs;
    logic                       r_err_now;

    logic                       unused_ids;

    assign unused_ids = ^{b_id, r_id};

    assign aligned  = cmd_addr & ~ADDRESS_WIDTH'(BYTES - 1);
    assign span     = ({9'd0, cmd_len} + 17'd1) * 17'(BYTES);
    assign end_off  = {5'd0, aligned[11:0]} + span;
    assign cross_4k = end_off > 17'd4096;

    assign accept    = cmd_valid && cmd_ready;
    assign last_beat = (beat == len_q);
    assign w_hs      = (state == S_W) && wd_valid && w_ready;
    assign r_hs      = (state == S_R) && r_valid && rd_ready;
    assign r_err_now = (r_resp != 2'b00)
                     || (r_last && !last_beat)
                     || (last_beat && !r_last);

    // Fixed AXI attributes; addresses come from the aligned latched command
    assign aw_id     = ID_WIDTH'(MASTER_ID);
    assign aw_addr   = addr_q;
    assign aw_len    = len_q;
    assign aw_size   = 3'(SZ);
    assign aw_burst  = 2'b01;
    assign aw_cache  = 4'b0011;
    assign aw_prot   = 3'b000;
    assign aw_qos    = 4'b0000;
    assign aw_region = 4'b0000;
    assign ar_id     = ID_WIDTH'(MASTER_ID);
    assign ar_addr   = addr_q;
    assign ar_len    = len_q;
    assign ar_size   = 3'(SZ);
    assign ar_burst  = 2'b01;
    assign ar_cache  = 4'b0011;
    assign ar_prot   = 3'b000;
    assign ar_qos    = 4'b0000;
    assign ar_region = 4'b0000;

    assign w_data  = wd_data;
    assign w_strb  = wd_strb;
    assign rd_data = r_data;
    assign rd_last = r_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next state, channel enables and completion detection
    always_comb begin
        state_d   = state;
        cmd_ready = (state == S_IDLE) && !rst;
        aw_valid  = 1'b0;
        ar_valid  = 1'b0;
        w_valid   = 1'b0;
        wd_ready  = 1'b0;
        w_last    = 1'b0;
        b_ready   = 1'b0;
        rd_valid  = 1'b0;
        r_ready   = 1'b0;
        done      = 1'b0;
        done_err  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cross_4k)       state_d = S_ERR;
                    else if (cmd_write) state_d = S_AW;
                    else                state_d = S_AR;
                end
            end
            S_ERR: begin
                state_d  = S_IDLE;
                done     = 1'b1;
                done_err = 1'b1;
            end
            S_AW: begin
                aw_valid = 1'b1;
                if (aw_ready) state_d = S_W;
            end
            S_W: begin
                w_valid  = wd_valid;
                wd_ready = w_ready;
                w_last   = last_beat;
                if (w_hs && last_beat) state_d = S_B;
            end
            S_B: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    state_d  = S_IDLE;
                    done     = 1'b1;
                    done_err = (b_resp != 2'b00);
                end
            end
            S_AR: begin
                ar_valid = 1'b1;
                if (ar_ready) state_d = S_R;
            end
            S_R: begin
                rd_valid = r_valid;
                r_ready  = rd_ready;
                if (r_hs && (r_last || last_beat)) begin
                    state_d  = S_IDLE;
                    done     = 1'b1;
                    done_err = rd_err_q || r_err_now;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch, beat counter, sticky read error and response pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            len_q     <= '0;
            write_q   <= 1'b0;
            beat      <= '0;
            rd_err_q  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_write <= 1'b0;
        end else begin
            rsp_valid <= done;
            if (done) begin
                rsp_err   <= done_err;
                rsp_write <= write_q;
            end
            if (accept) begin
                addr_q   <= aligned;
                len_q    <= cmd_len;
                write_q  <= cmd_write;
                beat     <= '0;
                rd_err_q <= 1'b0;
            end else if (w_hs) begin
                beat <= beat + 8'd1;
            end else if (r_hs) begin
                beat     <= beat + 8'd1;
                rd_err_q <= rd_err_q || r_err_now;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: the bench plays the AXI slave and the
// command client cycle by cycle, driving at negedge and checking 1 ns later.
module tb_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic        rd_valid, rd_ready;
    logic [63:0] rd_data;
    logic        rd_last;
    logic        rsp_valid, rsp_write, rsp_err;
    logic [0:0]  aw_id, ar_id, b_id, r_id;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]  aw_burst, ar_burst;
    logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
    logic        aw_valid, aw_ready, ar_valid, ar_ready;
    logic [63:0] w_data, r_data;
    logic [7:0]  w_strb;
    logic        w_last, w_valid, w_ready;
    logic [1:0]  b_resp, r_resp;
    logic        b_valid, b_ready;
    logic        r_last, r_valid, r_ready;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    axi_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready),
        .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
        .aw_size(aw_size), .aw_burst(aw_burst), .aw_cache(aw_cache),
        .aw_prot(aw_prot), .aw_qos(aw_qos), .aw_region(aw_region),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_id(b_id), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache),
        .ar_prot(ar_prot), .ar_qos(ar_qos), .ar_region(ar_region),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 0; wd_data = '0; wd_strb = 8'hFF;
        rd_ready = 0; aw_ready = 0; ar_ready = 0; w_ready = 0;
        b_resp = 0; b_id = 0; b_valid = 0;
        r_id = 0; r_data = '0; r_resp = 0; r_last = 0; r_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        tick(); tick(); #1;
        vecs++; if (cmd_ready !== 1'b0) begin errs++; $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready); end
        vecs++; if ({aw_valid, ar_valid, w_valid, b_ready, r_ready} !== 5'b0) begin errs++; $display("FAIL rst_axi_valids: got %b exp 00000", {aw_valid, ar_valid, w_valid, b_ready, r_ready}); end
        vecs++; if ({rsp_valid, rd_valid, wd_ready, rsp_err, rsp_write} !== 5'b0) begin errs++; $display("FAIL rst_client: got %b exp 00000", {rsp_valid, rd_valid, wd_ready, rsp_err, rsp_write}); end
        rst = 0;
        tick(); #1;
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_write_burst();
        logic [63:0] exp_d;
        tick();
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h100; cmd_len = 8'd3;
        #1;
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL wr_cmd_ready: got %b exp 1", cmd_ready); end
        tick();
        cmd_valid = 0; wd_valid = 1; wd_data = 64'h11; w_ready = 1;
        #1;
        vecs++; if (aw_valid !== 1'b1) begin errs++; $display("FAIL wr_awv1: got %b exp 1", aw_valid); end
        vecs++; if (aw_addr !== 32'h100) begin errs++; $display("FAIL wr_aw_addr: got %h exp 100", aw_addr); end
        vecs++; if (aw_len !== 8'd3) begin errs++; $display("FAIL wr_aw_len: got %0d exp 3", aw_len); end
        vecs++; if ({aw_size, aw_burst, aw_cache} !== {3'd3, 2'b01, 4'b0011}) begin errs++; $display("FAIL wr_aw_attr: got %b exp 011010011", {aw_size, aw_burst, aw_cache}); end
        vecs++; if ({aw_prot, aw_qos, aw_region, aw_id} !== 12'b0) begin errs++; $display("FAIL wr_aw_zero: got %b exp 0", {aw_prot, aw_qos, aw_region, aw_id}); end
        vecs++; if ({w_valid, wd_ready} !== 2'b00) begin errs++; $display("FAIL wr_no_early_w: got %b exp 00", {w_valid, wd_ready}); end
        tick(); #1;
        vecs++; if ({aw_valid, aw_addr, aw_len} !== {1'b1, 32'h100, 8'd3}) begin errs++; $display("FAIL wr_aw_hold: got %b %h %0d exp 1 100 3", aw_valid, aw_addr, aw_len); end
        tick();
        aw_ready = 1;
        #1;
        vecs++; if (aw_valid !== 1'b1) begin errs++; $display("FAIL wr_awv3: got %b exp 1", aw_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            aw_ready = 0;
            exp_d = 64'h11 * 64'(i + 1);
            wd_data = exp_d;
            #1;
            vecs++; if ({w_valid, wd_ready, aw_valid} !== 3'b110) begin errs++; $display("FAIL wr_beat%0d_hs: got %b exp 110", i, {w_valid, wd_ready, aw_valid}); end
            vecs++; if (w_data !== exp_d || w_strb !== 8'hFF) begin errs++; $display("FAIL wr_beat%0d_data: got %h/%h exp %h/ff", i, w_data, w_strb, exp_d); end
            vecs++; if (w_last !== (i == 3)) begin errs++; $display("FAIL wr_beat%0d_last: got %b exp %b", i, w_last, (i == 3)); end
        end
        tick();
        wd_valid = 0; b_valid = 1; b_resp = 2'b00;
        #1;
        vecs++; if ({b_ready, w_valid} !== 2'b10) begin errs++; $display("FAIL wr_b_state: got %b exp 10", {b_ready, w_valid}); end
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL wr_rsp_early: got %b exp 0", rsp_valid); end
        tick();
        b_valid = 0;
        #1;
        vecs++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b110) begin errs++; $display("FAIL wr_rsp: got %b exp 110", {rsp_valid, rsp_write, rsp_err}); end
        vecs++; if ({cmd_ready, b_ready} !== 2'b10) begin errs++; $display("FAIL wr_idle: got %b exp 10", {cmd_ready, b_ready}); end
        tick(); #1;
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL wr_rsp_pulse: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_read_burst();
        int beat_i;
        tick();
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h100; cmd_len = 8'd3;
        #1;
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rd_cmd_ready: got %b exp 1", cmd_ready); end
        tick();
        cmd_valid = 0; ar_ready = 1; r_valid = 1; r_data = 64'hA0;
        #1;
        vecs++; if ({ar_valid, ar_addr, ar_len} !== {1'b1, 32'h100, 8'd3}) begin errs++; $display("FAIL rd_ar: got %b %h %0d exp 1 100 3", ar_valid, ar_addr, ar_len); end
        vecs++; if ({aw_valid, rd_valid, r_ready} !== 3'b000) begin errs++; $display("FAIL rd_ar_quiet: got %b exp 000", {aw_valid, rd_valid, r_ready}); end
        beat_i = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            ar_ready = 0;
            rd_ready = (c % 2 == 0);
            r_data = 64'hA0 + 64'(beat_i);
            r_last = (beat_i == 3);
            #1;
            vecs++; if ({rd_valid, r_ready, ar_valid} !== {1'b1, rd_ready, 1'b0}) begin errs++; $display("FAIL rd_c%0d_hs: got %b exp 1%b0", c, {rd_valid, r_ready, ar_valid}, rd_ready); end
            vecs++; if (rd_data !== 64'hA0 + 64'(beat_i) || rd_last !== (beat_i == 3)) begin errs++; $display("FAIL rd_c%0d_data: got %h/%b exp %h/%b", c, rd_data, rd_last, 64'hA0 + 64'(beat_i), (beat_i == 3)); end
            if (rd_ready) beat_i++;
        end
        tick();
        r_valid = 0; r_last = 0; rd_ready = 0;
        #1;
        vecs++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b100) begin errs++; $display("FAIL rd_rsp: got %b exp 100", {rsp_valid, rsp_write, rsp_err}); end
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rd_idle: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_4k_cross();
        tick();
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hFF8; cmd_len = 8'd1;
        #1;
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL x4k_cmd_ready: got %b exp 1", cmd_ready); end
        tick();
        cmd_valid = 0;
        #1;
        vecs++; if ({aw_valid, ar_valid, rsp_valid, cmd_ready} !== 4'b0000) begin errs++; $display("FAIL x4k_err_cycle: got %b exp 0000", {aw_valid, ar_valid, rsp_valid, cmd_ready}); end
        tick(); #1;
        vecs++; if ({rsp_valid, rsp_err, aw_valid} !== 3'b110) begin errs++; $display("FAIL x4k_rsp: got %b exp 110", {rsp_valid, rsp_err, aw_valid}); end
        tick(); #1;
        vecs++; if ({rsp_valid, aw_valid, cmd_ready} !== 3'b001) begin errs++; $display("FAIL x4k_after: got %b exp 001", {rsp_valid, aw_valid, cmd_ready}); end
    endtask

    task automatic test_4k_edge_unaligned();
        tick();
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'hFFB; cmd_len = 8'd0;
        #1;
        tick();
        cmd_valid = 0; ar_ready = 1;
        #1;
        vecs++; if ({ar_valid, ar_addr, ar_len} !== {1'b1, 32'hFF8, 8'd0}) begin errs++; $display("FAIL edge_ar: got %b %h %0d exp 1 ff8 0", ar_valid, ar_addr, ar_len); end
        tick();
        ar_ready = 0; r_valid = 1; r_last = 1; rd_ready = 1; r_data = 64'h5A;
        #1;
        vecs++; if ({rd_valid, rd_last, rd_data} !== {2'b11, 64'h5A}) begin errs++; $display("FAIL edge_r: got %b %b %h exp 1 1 5a", rd_valid, rd_last, rd_data); end
        tick();
        r_valid = 0; r_last = 0; rd_ready = 0;
        #1;
        vecs++; if ({rsp_valid, rsp_err, rsp_write} !== 3'b100) begin errs++; $display("FAIL edge_rsp: got %b exp 100", {rsp_valid, rsp_err, rsp_write}); end
    endtask

    task automatic test_back_to_back();
        tick();
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h400; cmd_len = 8'd3;
        #1;
        tick();
        cmd_valid = 0; ar_ready = 1;
        #1;
        vecs++; if ({ar_valid, ar_len} !== {1'b1, 8'd3}) begin errs++; $display("FAIL early_ar: got %b %0d exp 1 3", ar_valid, ar_len); end
        tick();
        ar_ready = 0; r_valid = 1; rd_ready = 1; r_last = 0; r_data = 64'h1;
        #1;
        vecs++; if (rd_valid !== 1'b1) begin errs++; $display("FAIL early_b0: got %b exp 1", rd_valid); end
        tick();
        r_last = 1; r_data = 64'h2;
        #1;
        vecs++; if ({rd_valid, rd_last} !== 2'b11) begin errs++; $display("FAIL early_b1: got %b exp 11", {rd_valid, rd_last}); end
        tick();
        r_valid = 0; r_last = 0; rd_ready = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h200; cmd_len = 8'd0;
        #1;
        vecs++; if ({rsp_valid, rsp_err, rsp_write} !== 3'b110) begin errs++; $display("FAIL early_rsp: got %b exp 110", {rsp_valid, rsp_err, rsp_write}); end
        vecs++; if ({cmd_ready, rd_valid, r_ready} !== 3'b100) begin errs++; $display("FAIL b2b_ready: got %b exp 100", {cmd_ready, rd_valid, r_ready}); end
        tick();
        cmd_valid = 0; aw_ready = 1;
        #1;
        vecs++; if ({aw_valid, aw_addr, aw_len} !== {1'b1, 32'h200, 8'd0}) begin errs++; $display("FAIL b2b_aw: got %b %h %0d exp 1 200 0", aw_valid, aw_addr, aw_len); end
        tick();
        aw_ready = 0; wd_valid = 1; wd_data = 64'hBEEF; w_ready = 1;
        #1;
        vecs++; if ({w_valid, w_last, w_data} !== {2'b11, 64'hBEEF}) begin errs++; $display("FAIL len0_w: got %b %b %h exp 1 1 beef", w_valid, w_last, w_data); end
        tick();
        wd_valid = 0; b_valid = 1; b_resp = 2'b10;
        #1;
        vecs++; if ({b_ready, w_valid} !== 2'b10) begin errs++; $display("FAIL slverr_b: got %b exp 10", {b_ready, w_valid}); end
        tick();
        b_valid = 0; b_resp = 0;
        #1;
        vecs++; if ({rsp_valid, rsp_err, rsp_write} !== 3'b111) begin errs++; $display("FAIL slverr_rsp: got %b exp 111", {rsp_valid, rsp_err, rsp_write}); end
    endtask

    task automatic test_reset_mid_burst();
        tick();
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h300; cmd_len = 8'd7;
        #1;
        tick();
        cmd_valid = 0; aw_ready = 1;
        #1;
        tick();
        aw_ready = 0; wd_valid = 1; w_ready = 1; wd_data = 64'h1;
        #1;
        vecs++; if ({w_valid, w_last} !== 2'b10) begin errs++; $display("FAIL mid_beat0: got %b exp 10", {w_valid, w_last}); end
        tick();
        wd_data = 64'h2; rst = 1;
        #1;
        vecs++; if ({w_valid, cmd_ready} !== 2'b10) begin errs++; $display("FAIL mid_beat1: got %b exp 10", {w_valid, cmd_ready}); end
        tick();
        rst = 0;
        #1;
        vecs++; if ({aw_valid, ar_valid, w_valid, wd_ready, b_ready} !== 5'b0) begin errs++; $display("FAIL mid_valids: got %b exp 00000", {aw_valid, ar_valid, w_valid, wd_ready, b_ready}); end
        vecs++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errs++; $display("FAIL mid_idle: got %b exp 01", {rsp_valid, cmd_ready}); end
        tick();
        wd_valid = 0; w_ready = 0;
        #1;
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL mid_no_rsp: got %b exp 0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_4k_cross();
        test_4k_edge_unaligned();
        test_back_to_back();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
